// File: rtl/handshakes_delay_valid_data.sv
// ---------------------------------------------------------------------------
// handshakes_delay_valid_data
//
// Forward register slice for a valid/ready stream. It adds one clock of
// latency on the valid/data path without losing or duplicating beats. It
// sustains one transfer per cycle while the consumer stays ready.
//
// Build option:
//   HSK_DVD_SKID_EN  adds a skid register (capacity 2) and registers
//                    up_ready, which removes the combinational
//                    down_ready -> up_ready path.
//   (undefined)      uses a single register. up_ready is then
//                    !down_valid || down_ready.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   up_valid    upstream beat present
//   up_data     upstream payload [WORD_WIDTH-1:0]
//   up_ready    stage can accept a beat this cycle
//   down_valid  registered beat available downstream
//   down_data   registered payload [WORD_WIDTH-1:0]
//   down_ready  downstream accepts the beat this cycle
// ---------------------------------------------------------------------------
module handshakes_delay_valid_data #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] data_q,  data_d;

`ifdef HSK_DVD_SKID_EN

  logic                  skid_valid_q, skid_valid_d;
  logic [WORD_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  up_ready_q,   up_ready_d;
  logic                  main_open;

  // up_ready_q is always !skid_valid_q. A skid beat therefore never coincides
  // with an upstream transfer, so the main register has one source per cycle.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    main_open    = !valid_q || down_ready;

    if (main_open) begin
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = up_valid && up_ready_q;
        if (up_valid && up_ready_q) begin
          data_d = up_data;
        end
      end
    end else if (up_valid && up_ready_q) begin
      // Main register is held by a stalled consumer; park the new beat.
      skid_valid_d = 1'b1;
      skid_data_d  = up_data;
    end

    up_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      up_ready_q   <= 1'b1;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      up_ready_q   <= up_ready_d;
    end
  end

  assign up_ready = up_ready_q;

`else

  // Accept when empty or when the held beat leaves in this same cycle.
  assign up_ready = !valid_q || down_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

  assign down_valid = valid_q;
  assign down_data  = data_q;

endmodule

// File: tb/tb_handshakes_delay_valid_data.sv
module tb_handshakes_delay_valid_data;

  localparam int W = 8;
`ifdef HSK_DVD_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         up_valid;
  logic [W-1:0] up_data;
  logic         up_ready;
  logic         down_valid;
  logic [W-1:0] down_data;
  logic         down_ready;

  int checks = 0;
  int errors = 0;

  handshakes_delay_valid_data #(.WORD_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         uv;
    logic [W-1:0] ud;
    logic         dr;
    logic         exp_ur;
    logic         exp_dv;
    logic         chk_dd;
    logic [W-1:0] exp_dd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    up_valid   = v;
    up_data    = d;
    down_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    // Assert between edges, check immediately, release on the falling edge.
    rst_n = 1'b0;
    #1;
    chk("async_rst_dv", 32'(down_valid), 32'd0);
    chk("async_rst_dd", 32'(down_data), 32'd0);
    chk("async_rst_ur", 32'(up_ready), 32'd1);
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] mq[$];
    logic [W-1:0] consumed[$];
    logic [W-1:0] src;
    logic         ur_s, dv_s;
    logic [W-1:0] dd_s;
    logic         exp_ur, dfire, ufire;
    int           pat[8];

    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
    vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44};
    vecs[4] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55};
    vecs[5] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset and fill against a stalled sink
    rst_n = 1'b0;
    drive(1'b1, 8'h00, 1'b0);
    chk("rst_dv", 32'(down_valid), 32'd0);
    chk("rst_dd", 32'(down_data), 32'd0);
    chk("rst_ur", 32'(up_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("fill_dv", 32'(down_valid), 32'd1);
    chk("fill_dd", 32'(down_data), 32'd0);
`ifdef HSK_DVD_SKID_EN
    chk("fill_ur", 32'(up_ready), 32'd1);
`else
    chk("fill_ur", 32'(up_ready), 32'd0);
`endif

    // Stall hold: the held beat must not move or be overwritten
    up_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_dv", 32'(down_valid), 32'd1);
      chk("stall_dd", 32'(down_data), 32'd0);
`ifndef HSK_DVD_SKID_EN
      chk("stall_ur", 32'(up_ready), 32'd0);
`endif
    end

    // Asynchronous reset in the middle of the stall
    #3;
    async_reset();

    // Streaming table, then one idle row
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].uv, vecs[i].ud, vecs[i].dr);
      chk("tbl_ur", 32'(up_ready), 32'(vecs[i].exp_ur));
      tick();
      chk("tbl_dv", 32'(down_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].chk_dd) chk("tbl_dd", 32'(down_data), 32'(vecs[i].exp_dd));
    end

    // Drain: hold a beat, drop up_valid, then let it go
    drive(1'b1, 8'h77, 1'b1);
    tick();
    chk("drain_fill_dv", 32'(down_valid), 32'd1);
    chk("drain_fill_dd", 32'(down_data), 32'h77);
    drive(1'b0, 8'h00, 1'b0);
`ifdef HSK_DVD_SKID_EN
    chk("drain_hold_ur", 32'(up_ready), 32'd1);
`else
    chk("drain_hold_ur", 32'(up_ready), 32'd0);
`endif
    tick();
    chk("drain_hold_dv", 32'(down_valid), 32'd1);
    chk("drain_hold_dd", 32'(down_data), 32'h77);
    drive(1'b0, 8'h00, 1'b1);
    chk("drain_go_ur", 32'(up_ready), 32'd1);
    tick();
    chk("drain_empty_dv", 32'(down_valid), 32'd0);
    chk("drain_last_dd", 32'(down_data), 32'h77);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("drain_idle_dv", 32'(down_valid), 32'd0);
    chk("drain_dd_known", 32'($isunknown(down_data)), 32'd0);

    // Single-cycle ready pulses with an advancing source
    src = 8'hA0;
    drive(1'b1, src, 1'b0);
    chk("pulse_empty_ur", 32'(up_ready), 32'd1);
    tick();
    src = src + 8'd1;
    pat = '{1, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, src, pat[i][0]);
      ur_s = up_ready;
      dv_s = down_valid;
      dd_s = down_data;
      if (pat[i] == 1 && dv_s) consumed.push_back(dd_s);
      tick();
      if (ur_s) src = src + 8'd1;
    end
    chk("pulse_count", 32'(consumed.size()), 32'd2);
    if (consumed.size() >= 2) begin
      chk("pulse_beat0", 32'(consumed[0]), 32'hA0);
      chk("pulse_beat1", 32'(consumed[1]), 32'hA1);
    end

    // Randomised traffic against a queue model of the stage
    #3;
    async_reset();
    mq.delete();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, W'($urandom),
            (i < 300) ? (($urandom % 3) != 0) : (($urandom % 3) == 0));
      if (CAP == 1) exp_ur = (mq.size() == 0) || down_ready;
      else          exp_ur = (mq.size() < CAP);
      chk("rnd_ur", 32'(up_ready), 32'(exp_ur));
      chk("rnd_dv", 32'(down_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("rnd_dd", 32'(down_data), 32'(mq[0]));
      dfire = (mq.size() > 0) && down_ready;
      ufire = up_valid && exp_ur;
      if (dfire) void'(mq.pop_front());
      if (ufire) mq.push_back(up_data);
      tick();
    end
    chk("rnd_end_dv", 32'(down_valid), 32'(mq.size() > 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
